// File: rtl/code_sender_pkg.sv
// Shared types and defaults for the code sender: FSM state encoding,
// default phase lengths and small elaboration-time helpers.
package code_sender_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SETUP    = 3'd1,
    ST_PRESS    = 3'd2,
    ST_GAP      = 3'd3,
    ST_WAIT_RSP = 3'd4,
    ST_FINISH   = 3'd5
  } state_e;

  localparam int unsigned N_DIGITS_DEF    = 32'd4;
  localparam int unsigned HOLD_CYC_DEF    = 32'd5;
  localparam int unsigned GAP_CYC_DEF     = 32'd16;
  localparam int unsigned TIMEOUT_CYC_DEF = 32'd1024;

  // Largest of three phase lengths; sizes the shared timer.
  function automatic int unsigned max3(input int unsigned a,
                                       input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Counter width for a phase of max_cnt cycles (loaded with max_cnt-1).
  function automatic int unsigned timer_width(input int unsigned max_cnt);
    return ($clog2(max_cnt) < 1) ? 32'd1 : $clog2(max_cnt);
  endfunction

endpackage

// File: rtl/code_sender_cycle_timer.sv
// Loadable down-counter shared by the HOLD, GAP and response-timeout
// phases. Loading N-1 makes expired_o rise after N cycles in the phase.
module cycle_timer #(
  parameter int unsigned WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  output logic             expired_o
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  // Next count: load wins, otherwise count down and park at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != {WIDTH{1'b0}}) begin
      cnt_d = cnt_q - WIDTH'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= {WIDTH{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == {WIDTH{1'b0}});

endmodule

// File: rtl/code_sender.sv
// Code sender: presents a multi-digit key code to a lock, strobing enter
// once per digit, then waits for OPEN/ERROR or gives up after a timeout.
module code_sender
  import code_sender_pkg::*;
#(
  parameter int unsigned N_DIGITS    = N_DIGITS_DEF,
  parameter int unsigned HOLD_CYC    = HOLD_CYC_DEF,
  parameter int unsigned GAP_CYC     = GAP_CYC_DEF,
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [2*N_DIGITS-1:0] code,
  input  logic                  OPEN,
  input  logic                  ERROR,
  output logic                  keyA,
  output logic                  keyB,
  output logic                  enter,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic                  timeout
);

  localparam int unsigned TW    = timer_width(max3(HOLD_CYC, GAP_CYC, TIMEOUT_CYC));
  localparam int unsigned IDX_W = (N_DIGITS > 32'd1) ? $clog2(N_DIGITS) : 32'd1;

  localparam logic [TW-1:0]    HOLD_LD  = TW'(HOLD_CYC - 32'd1);
  localparam logic [TW-1:0]    GAP_LD   = TW'(GAP_CYC - 32'd1);
  localparam logic [TW-1:0]    TMO_LD   = TW'(TIMEOUT_CYC - 32'd1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_DIGITS - 32'd1);

  state_e                state_q, state_d;
  logic [2*N_DIGITS-1:0] code_q, code_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [1:0]            key_q, key_d;
  logic                  enter_q, enter_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  pass_q, pass_d;
  logic                  timeout_q, timeout_d;

  logic                  tmr_load_s;
  logic [TW-1:0]         tmr_val_s;
  logic                  tmr_exp_s;
  logic [IDX_W-1:0]      idx_nxt_s;
  logic [1:0]            next_digit_s;

  cycle_timer #(.WIDTH(TW)) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (tmr_load_s),
    .load_val_i (tmr_val_s),
    .expired_o  (tmr_exp_s)
  );

  // Select the digit that follows the current index from the latched code.
  always_comb begin
    idx_nxt_s    = idx_q + IDX_W'(1);
    next_digit_s = 2'b00;
    for (int i = 0; i < int'(N_DIGITS); i++) begin
      next_digit_s = (idx_nxt_s == IDX_W'(i)) ? code_q[2*i +: 2] : next_digit_s;
    end
  end

  // Next-state and next-output logic; outputs are registered below.
  always_comb begin
    state_d    = state_q;
    code_d     = code_q;
    idx_d      = idx_q;
    key_d      = key_q;
    enter_d    = 1'b0;
    busy_d     = busy_q;
    done_d     = 1'b0;
    pass_d     = pass_q;
    timeout_d  = timeout_q;
    tmr_load_s = 1'b0;
    tmr_val_s  = {TW{1'b0}};
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          code_d    = code;
          idx_d     = {IDX_W{1'b0}};
          key_d     = code[1:0];
          pass_d    = 1'b0;
          timeout_d = 1'b0;
          busy_d    = 1'b1;
          state_d   = ST_SETUP;
        end else begin
          state_d   = ST_IDLE;
        end
      end
      ST_SETUP: begin
        enter_d    = 1'b1;
        tmr_load_s = 1'b1;
        tmr_val_s  = HOLD_LD;
        state_d    = ST_PRESS;
      end
      ST_PRESS: begin
        if (tmr_exp_s) begin
          tmr_load_s = 1'b1;
          tmr_val_s  = GAP_LD;
          state_d    = ST_GAP;
        end else begin
          enter_d    = 1'b1;
        end
      end
      ST_GAP: begin
        if (!tmr_exp_s) begin
          state_d = ST_GAP;
        end else if (idx_q != LAST_IDX) begin
          idx_d   = idx_nxt_s;
          key_d   = next_digit_s;
          state_d = ST_SETUP;
        end else begin
          tmr_load_s = 1'b1;
          tmr_val_s  = TMO_LD;
          state_d    = ST_WAIT_RSP;
        end
      end
      ST_WAIT_RSP: begin
        // ERROR outranks OPEN; a response on the final cycle beats timeout.
        if (ERROR) begin
          pass_d  = 1'b0;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_FINISH;
        end else if (OPEN) begin
          pass_d  = 1'b1;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_FINISH;
        end else if (tmr_exp_s) begin
          timeout_d = 1'b1;
          done_d    = 1'b1;
          busy_d    = 1'b0;
          state_d   = ST_FINISH;
        end else begin
          state_d = ST_WAIT_RSP;
        end
      end
      ST_FINISH: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      code_q    <= {(2*N_DIGITS){1'b0}};
      idx_q     <= {IDX_W{1'b0}};
      key_q     <= 2'b00;
      enter_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      code_q    <= code_d;
      idx_q     <= idx_d;
      key_q     <= key_d;
      enter_q   <= enter_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
      timeout_q <= timeout_d;
    end
  end

  assign keyA    = key_q[1];
  assign keyB    = key_q[0];
  assign enter   = enter_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign pass    = pass_q;
  assign timeout = timeout_q;

endmodule
